// File: rtl/mem_rd_arbiter.sv
// rtl/mem_rd_arbiter.sv - round-robin read arbiter sharing one memory read port between I-cache and D-cache
module mem_rd_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        from_ic_rd_req_valid,
    input  logic [31:0] from_ic_rd_req_addr,
    input  logic [7:0]  from_ic_rd_req_len,
    output logic        to_ic_rd_req_ready,
    output logic        to_ic_rd_rsp_valid,
    output logic [31:0] to_ic_rd_rsp_data,
    output logic        to_ic_rd_rsp_last,
    input  logic        from_ic_rd_rsp_ready,

    input  logic        from_dc_rd_req_valid,
    input  logic [31:0] from_dc_rd_req_addr,
    input  logic [7:0]  from_dc_rd_req_len,
    output logic        to_dc_rd_req_ready,
    output logic        to_dc_rd_rsp_valid,
    output logic [31:0] to_dc_rd_rsp_data,
    output logic        to_dc_rd_rsp_last,
    input  logic        from_dc_rd_rsp_ready,

    output logic        to_mem_rd_req_valid,
    output logic [31:0] to_mem_rd_req_addr,
    output logic [7:0]  to_mem_rd_req_len,
    input  logic        from_mem_rd_req_ready,
    input  logic        from_mem_rd_rsp_valid,
    input  logic [31:0] from_mem_rd_rsp_data,
    input  logic        from_mem_rd_rsp_last,
    output logic        to_mem_rd_rsp_ready,

    output logic        owner
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        REQ  = 3'b010,
        RESP = 3'b100
    } state_t;

    state_t      r_state;
    logic        r_owner;       // 0 = I-cache, 1 = D-cache
    logic        r_prefer_dc;   // port that wins the next tie
    logic [7:0]  r_beat_cnt;    // beats still expected in the current burst

    logic        w_any_req;
    logic        w_grant_dc;
    logic [7:0]  w_owner_len;
    logic        w_owner_rsp_ready;
    logic        w_beat_xfer;

    // A lone request always wins; on a tie the round-robin pointer decides.
    assign w_any_req         = from_ic_rd_req_valid | from_dc_rd_req_valid;
    assign w_grant_dc        = from_dc_rd_req_valid & (~from_ic_rd_req_valid | r_prefer_dc);
    assign w_owner_len       = r_owner ? from_dc_rd_req_len : from_ic_rd_req_len;
    assign w_owner_rsp_ready = r_owner ? from_dc_rd_rsp_ready : from_ic_rd_rsp_ready;
    assign w_beat_xfer       = (r_state == RESP) & from_mem_rd_rsp_valid & w_owner_rsp_ready;

    assign owner = r_owner;

    // Grant FSM: arbitrate in IDLE, hold the request in REQ, stream beats in RESP until memory flags last.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_prefer_dc <= 1'b1;
            r_beat_cnt  <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_grant_dc;
                        r_prefer_dc <= ~w_grant_dc;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (from_mem_rd_req_ready) begin
                        r_beat_cnt <= w_owner_len;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    if (w_beat_xfer) begin
                        r_beat_cnt <= r_beat_cnt - 8'd1;
                        if (from_mem_rd_rsp_last) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Route request and response channels to the owning port; everything else is held idle.
    always_comb begin
        to_mem_rd_req_valid = 1'b0;
        to_mem_rd_req_addr  = r_owner ? from_dc_rd_req_addr : from_ic_rd_req_addr;
        to_mem_rd_req_len   = w_owner_len;
        to_mem_rd_rsp_ready = 1'b0;
        to_ic_rd_req_ready  = 1'b0;
        to_dc_rd_req_ready  = 1'b0;
        to_ic_rd_rsp_valid  = 1'b0;
        to_dc_rd_rsp_valid  = 1'b0;
        to_ic_rd_rsp_data   = from_mem_rd_rsp_data;
        to_dc_rd_rsp_data   = from_mem_rd_rsp_data;
        to_ic_rd_rsp_last   = 1'b0;
        to_dc_rd_rsp_last   = 1'b0;

        if (r_state == REQ) begin
            to_mem_rd_req_valid = 1'b1;
            if (r_owner) begin
                to_dc_rd_req_ready = from_mem_rd_req_ready;
            end else begin
                to_ic_rd_req_ready = from_mem_rd_req_ready;
            end
        end

        if (r_state == RESP) begin
            to_mem_rd_rsp_ready = w_owner_rsp_ready;
            if (r_owner) begin
                to_dc_rd_rsp_valid = from_mem_rd_rsp_valid;
                to_dc_rd_rsp_last  = from_mem_rd_rsp_last;
            end else begin
                to_ic_rd_rsp_valid = from_mem_rd_rsp_valid;
                to_ic_rd_rsp_last  = from_mem_rd_rsp_last;
            end
        end
    end

endmodule
